// File: rtl/dsm_input_sequencer_pkg.sv
// dsm_input_sequencer_pkg: shared symbol codes, state encodings and widths for the input sequencer
package dsm_input_sequencer_pkg;
  localparam int SAMPLE_W = 15;
  localparam logic [1:0] PWM_POS  = 2'b01;
  localparam logic [1:0] PWM_NEG  = 2'b11;
  localparam logic [1:0] PWM_ZERO = 2'b00;
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RUN       = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_t;
  // Only the two full-scale codes count towards overload; 00 and 10 both mean zero.
  function automatic logic pwm_nonzero(input logic [1:0] p);
    return p == PWM_POS || p == PWM_NEG;
  endfunction
endpackage

// File: rtl/dsm_input_sequencer_fifo.sv
// dsm_sample_fifo: small synchronous FIFO with flush, pointer MSB distinguishes full from empty
module dsm_sample_fifo #(
  parameter int W     = 15,
  parameter int DEPTH = 4
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr, r_rd;
  logic         w_push, w_pop;
  assign o_empty = r_wr == r_rd;
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_data  = r_mem[r_rd[AW-1:0]];
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;
  // Pointers: flush empties the FIFO and drops any same-cycle push
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PTR_ONE;
      if (w_pop) r_rd <= r_rd + PTR_ONE;
    end
  end
  // Storage needs no reset; the pointers decide what is valid
  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/dsm_input_sequencer.sv
// dsm_input_sequencer: paces samples into the modulator with soft-start/stop gain and overload guard
module dsm_input_sequencer
  import dsm_input_sequencer_pkg::*;
#(
  parameter int RATIO      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int OVL_LIMIT  = 64,
  parameter int GAIN_BITS  = 4
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_clear_flags,
  input  logic                i_s_valid,
  input  logic [SAMPLE_W-1:0] i_s_data,
  output logic                o_s_ready,
  output logic [SAMPLE_W-1:0] o_vin,
  output logic                o_sample_stb,
  input  logic [1:0]          i_pwm,
  output logic [1:0]          o_state,
  output logic                o_underflow,
  output logic                o_overload
);
  localparam int RW = $clog2(RATIO);
  localparam int GW = GAIN_BITS + 1;
  localparam int NW = $clog2(OVL_LIMIT + 1);
  localparam int PW = SAMPLE_W + GAIN_BITS + 1;
  localparam logic [RW-1:0] RATE_LAST = RW'(RATIO - 1);
  localparam logic [RW-1:0] RATE_ONE  = RW'(1);
  localparam logic [GW-1:0] G_UNITY   = GW'(1 << GAIN_BITS);
  localparam logic [GW-1:0] G_ONE     = GW'(1);
  localparam logic [NW-1:0] RUN_LIMIT = NW'(OVL_LIMIT);
  localparam logic [NW-1:0] RUN_ONE   = NW'(1);

  state_t                r_state, w_state_next;
  logic [RW-1:0]         r_rate;
  logic [GW-1:0]         r_gain, w_gain_next;
  logic [NW-1:0]         r_run, w_run_next;
  logic [1:0]            r_pwm_prev;
  logic [SAMPLE_W-1:0]   r_last, r_vin, w_sample, w_fifo_data;
  logic signed [PW-1:0]  w_prod, w_scaled;
  logic                  r_stb, r_unf, r_ovl;
  logic                  w_active, w_mon, w_strobe, w_to_idle;
  logic                  w_fifo_full, w_fifo_empty, w_ovl_set, w_unf_set;

  dsm_sample_fifo #(.W(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (i_s_valid && !w_fifo_full),
    .i_pop   (w_strobe && !w_fifo_empty),
    .i_flush (w_to_idle),
    .i_data  (i_s_data),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign o_s_ready    = !w_fifo_full;
  assign o_vin        = r_vin;
  assign o_sample_stb = r_stb;
  assign o_state      = r_state;
  assign o_underflow  = r_unf;
  assign o_overload   = r_ovl;

  // State register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else r_state <= w_state_next;
  end

  // Next state: prefill gate, ramp completion, and stop on disable or overload
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:
        if (i_enable && w_fifo_full && !r_ovl) w_state_next = ST_RAMP_UP;
      ST_RAMP_UP, ST_RUN:
        if (!i_enable || r_ovl) w_state_next = ST_RAMP_DOWN;
        else if (r_state == ST_RAMP_UP && w_strobe && w_gain_next == G_UNITY) w_state_next = ST_RUN;
      ST_RAMP_DOWN:
        if (w_to_idle) w_state_next = ST_IDLE;
    endcase
  end

  // State-derived controls: strobe pacing, monitor window, return to idle
  always_comb begin
    w_active  = r_state != ST_IDLE;
    w_mon     = r_state == ST_RAMP_UP || r_state == ST_RUN;
    w_strobe  = w_active && r_rate == RATE_LAST;
    w_to_idle = r_state == ST_RAMP_DOWN && w_strobe && w_gain_next == '0;
  end

  // Gain step and scaled sample; a ramp-down starting at zero gain ends at zero
  always_comb begin
    w_gain_next = r_state == ST_RAMP_UP ? r_gain + G_ONE :
                  r_state == ST_RUN     ? G_UNITY :
                  r_gain == '0          ? '0 : r_gain - G_ONE;
    w_sample    = w_fifo_empty ? r_last : w_fifo_data;
    w_prod      = PW'($signed(w_sample)) * $signed(PW'(w_gain_next));
    w_scaled    = w_prod >>> GAIN_BITS;
  end

  // Overload run length of identical full-scale symbols, saturating at the limit
  always_comb begin
    w_run_next = !pwm_nonzero(i_pwm) ? '0 :
                 i_pwm != r_pwm_prev ? RUN_ONE :
                 r_run == RUN_LIMIT  ? r_run : r_run + RUN_ONE;
    w_ovl_set  = w_mon && w_run_next == RUN_LIMIT;
    w_unf_set  = w_mon && w_strobe && w_fifo_empty;
  end

  // Rate counter: held at zero while idle, wraps every RATIO clocks otherwise
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_rate <= '0;
    else r_rate <= (!w_active || r_rate == RATE_LAST) ? '0 : r_rate + RATE_ONE;
  end

  // Sample path: on each strobe latch gain, remember sample, present scaled vin
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_gain <= '0;
      r_last <= '0;
      r_vin  <= '0;
      r_stb  <= 1'b0;
    end else begin
      r_stb <= w_strobe;
      if (w_strobe) begin
        r_gain <= w_gain_next;
        r_last <= w_sample;
        r_vin  <= w_scaled[SAMPLE_W-1:0];
      end
    end
  end

  // Overload monitor history: counts only while ramping up or running, cleared in idle
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pwm_prev <= PWM_ZERO;
      r_run      <= '0;
    end else begin
      r_pwm_prev <= i_pwm;
      r_run      <= w_mon ? w_run_next : (r_state == ST_IDLE ? '0 : r_run);
    end
  end

  // Sticky flags: a set in the same cycle as clear_flags wins
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_unf <= 1'b0;
      r_ovl <= 1'b0;
    end else begin
      r_unf <= w_unf_set || (r_unf && !i_clear_flags);
      r_ovl <= w_ovl_set || (r_ovl && !i_clear_flags);
    end
  end
endmodule

// File: doc/dsm_input_sequencer.md
Name: dsm_input_sequencer

Overview:
- Sequences the sample stream into the delta-sigma modulator core.
- Buffers upstream samples in a small FIFO and issues one sample every RATIO modulator clocks.
- Applies a soft-start/soft-stop gain ramp so vin never steps abruptly.
- Monitors the modulator's pwm output for overload (long runs of one full-scale symbol) and forces a ramp-down when it occurs.

Parameters:
- RATIO, 8, modulator clocks per input sample (≥2).
- FIFO_DEPTH, 4, sample FIFO entries (power of 2).
- OVL_LIMIT, 64, consecutive identical nonzero pwm symbols that constitute overload.
- GAIN_BITS, 4, ramp resolution; unity gain = 2^GAIN_BITS = 16, ramp length 16 samples.

Ports:
- clock  in  1  modulator clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  level; request to run.
- clear_flags  in  1  pulse; clears sticky underflow/overload.
- s_valid  in  1  upstream sample valid.
- s_data  in  15  upstream signed sample.
- s_ready  out  1  FIFO can accept.
- vin  out  15  signed sample to modulator, registered.
- sample_stb  out  1  one-clock pulse, vin updated this cycle.
- pwm  in  2  modulator output: 01=+1, 11=-1, 00/10=0.
- state  out  2  0 IDLE, 1 RAMP_UP, 2 RUN, 3 RAMP_DOWN.
- underflow  out  1  sticky.
- overload  out  1  sticky.

Behaviour:
- Reset values:
  - vin=0, sample_stb=0, state=IDLE, gain=0.
  - FIFO empty; s_ready=1.
  - rate counter=0, run counter=0.
  - underflow=0, overload=0.
- FIFO: push on s_valid&&s_ready; s_ready = !full. Simultaneous push+pop when full is not possible (s_ready=0). When empty, a push and a pop in the same cycle do not forward; the pop is treated as empty.
- Rate counter: cleared on the IDLE→RAMP_UP transition, then counts 0..RATIO-1 with wrap. A strobe cycle occurs at count==RATIO-1 in any non-IDLE state. Registered sample_stb and vin update on the edge ending that cycle, so the first strobe comes RATIO clocks after leaving IDLE.
- On a strobe cycle:
  - If the FIFO is non-empty, pop one sample.
  - Otherwise reuse the last sample. This sets underflow if state is RAMP_UP or RUN; no flag in RAMP_DOWN.
- Gain on each strobe:
  - RAMP_UP: g' = g+1.
  - RUN: g' = 16.
  - RAMP_DOWN: g' = g-1.
- vin = (sample * g') >>> GAIN_BITS. The product is 20-bit signed, the shift is arithmetic (rounds toward -inf), and the result fits 15 bits because g' ≤ 16. At g'=16, vin equals the sample exactly.
- FSM transitions:
  - IDLE→RAMP_UP: enable && FIFO full (prefill) && !overload.
  - RAMP_UP→RUN: on the strobe where g' = 16.
  - RAMP_UP/RUN→RAMP_DOWN: !enable, or overload being set. This takes effect at the next clock edge; the ramp descends from the current g.
  - RAMP_DOWN→IDLE: on the strobe where g' = 0. In that same edge the FIFO is flushed (any same-cycle push is dropped), vin=0, and the rate counter is cleared.
  - enable reasserted during RAMP_DOWN is ignored until IDLE is reached.
- Overload monitor:
  - Active in RAMP_UP and RUN only.
  - Run counter increments while pwm equals its previous-cycle value and is +1 or -1. It reloads to 1 on a change to a nonzero symbol and to 0 on a zero symbol; it saturates.
  - When it reaches OVL_LIMIT, set overload.
  - The counter clears on entering IDLE.
- clear_flags clears both sticky flags. A set in the same cycle wins.
- Async reset mid-operation returns everything to reset values immediately; no ramp.

Decomposition:
- Shared package: pwm symbol codes (PWM_POS=01, PWM_NEG=11, PWM_ZERO=00), state encodings, SAMPLE_W=15.
- Sub-module: dsm_sample_fifo (parameterised synchronous FIFO with push/pop/full/empty/flush).
- FSM, rate counter, gain multiply, and overload monitor stay in the top.

Test Plan:
- Prefill and start: push 4 samples of 16000, enable=1 → RAMP_UP after prefill; first sample_stb 8 clocks later with vin=1000. Then vin=2000, 3000, …; the 16th strobe gives vin=16000 and state=RUN.
- Negative rounding: sample -1 at g'=1 → vin=-1; sample -17 at g'=1 → vin=-2.
- Underflow: in RUN, stop s_valid until the FIFO is empty → the next strobe repeats the last vin and underflow=1. clear_flags → 0.
- Disable: enable=0 in RUN → 16 strobes with vin=15/16, 14/16, … 0 of the samples. Then state=IDLE, FIFO empty, s_ready=1, no further strobes.
- Overload: drive pwm=01 constantly in RUN → overload=1 at the 64th consecutive cycle, then RAMP_DOWN to IDLE. Re-enable stays in IDLE until clear_flags.
- Reset mid-RAMP_UP: assert reset between clock edges → vin=0, state=IDLE, flags cleared, s_ready=1 immediately.
